// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the digit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 14;
  localparam int DEF_DIGIT = 1;

  // Counter must hold WIDTH/DIGIT, the number of RUN cycles.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract cell: ripple of full-subtractor slices.
module sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] brw;

  assign brw[0] = bin;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_slice
      assign d[gi]       = x[gi] ^ y[gi] ^ brw[gi];
      assign brw[gi + 1] = (~x[gi] & y[gi]) | (~(x[gi] ^ y[gi]) & brw[gi]);
    end
  endgenerate

  assign bout = brw[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor, a - b over WIDTH/DIGIT cycles.
// Define SERIAL_SUB_CLAMP_EN to saturate negative results to zero.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff,
  output logic             neg
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = cnt_width(WIDTH, DIGIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic             neg_q, neg_d;

  logic [DIGIT-1:0]       dig_d;
  logic                   dig_bout;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH:0]         fin_diff;

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .x   (a_q[DIGIT-1:0]),
    .y   (b_q[DIGIT-1:0]),
    .bin (borrow_q),
    .d   (dig_d),
    .bout(dig_bout)
  );

  // New digit enters at the top; after STEPS shifts the LSB digit sits at bit 0.
  assign res_cat = {dig_d, res_q};

  always_comb begin
    fin_diff = {dig_bout, res_cat[WIDTH+DIGIT-1:DIGIT]};
`ifdef SERIAL_SUB_CLAMP_EN
    if (dig_bout) fin_diff = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    borrow_d    = borrow_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    neg_d       = neg_q;
    unique case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          borrow_d   = 1'b0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d      = a_q >> DIGIT;
        b_d      = b_q >> DIGIT;
        res_d    = res_cat[WIDTH+DIGIT-1:DIGIT];
        borrow_d = dig_bout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(STEPS - 1)) begin
          out_valid_d = 1'b1;
          diff_d      = fin_diff;
          neg_d       = dig_bout;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      borrow_q    <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      borrow_q    <= borrow_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      neg_q       <= neg_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor plus an operand sweep over DIGIT = 1, 2, 7, 14.
module tb_serial_subtractor;

  localparam int W = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [W-1:0]  a, b;
  logic [3:0]    ir, ov, ng;
  logic [W:0]    df [4];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic int dig_of(input int i);
    case (i)
      0:       return 1;
      1:       return 2;
      2:       return 7;
      default: return 14;
    endcase
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      serial_subtractor #(.WIDTH(W), .DIGIT(dig_of(gi))) u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (ir[gi]),
        .a        (a),
        .b        (b),
        .out_valid(ov[gi]),
        .out_ready(out_ready),
        .diff     (df[gi]),
        .neg      (ng[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and wait for the handshake edge; optionally keep in_valid high.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input bit hold);
    int n = 0;
    a = av;
    b = bv;
    in_valid = 1'b1;
    while (!ir[0] && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", 32'(ir[0]), 32'd1);
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit ir_low);
    lat = 0;
    ir_low = 1'b1;
    while (!ov[0] && lat < 40) begin
      if (ir[0]) ir_low = 1'b0;
      tick();
      lat++;
    end
    if (ir[0]) ir_low = 1'b0;
    $display("op a=%0d b=%0d -> diff=%0h neg=%0b latency=%0d", a, b, df[0], ng[0], lat);
  endtask

  function automatic logic [W:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] r;
    r = {1'b0, x} - {1'b0, y};
`ifdef SERIAL_SUB_CLAMP_EN
    if (x < y) r = '0;
`endif
    return r;
  endfunction

  initial begin
    int lat;
    bit irl;
    bit flag;
    int lat_k [4];
    logic [W:0] got [4];
    logic got_neg [4];
    bit seen [4];
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(ir[0]), 32'd1);
    check("rst_out_valid", 32'(ov[0]), 32'd0);
    check("rst_diff", 32'(df[0]), 32'd0);
    check("rst_neg", 32'(ng[0]), 32'd0);

    // a == b
    out_ready = 1'b1;
    accept(14'd1, 14'd1, 1'b0);
    wait_out(lat, irl);
    check("eq_latency", 32'(lat), 32'd14);
    check("eq_diff", 32'(df[0]), 32'd0);
    check("eq_neg", 32'(ng[0]), 32'd0);
    check("eq_in_ready_low", 32'(irl), 32'd1);
    tick();

    // 0 - 1
    accept(14'd0, 14'd1, 1'b0);
    wait_out(lat, irl);
`ifdef SERIAL_SUB_CLAMP_EN
    check("m1_diff", 32'(df[0]), 32'h0);
`else
    check("m1_diff", 32'(df[0]), 32'h7FFF);
`endif
    check("m1_neg", 32'(ng[0]), 32'd1);
    tick();

    // 0 - (2^W - 1)
    accept(14'd0, 14'h3FFF, 1'b0);
    wait_out(lat, irl);
`ifdef SERIAL_SUB_CLAMP_EN
    check("min_diff", 32'(df[0]), 32'h0);
`else
    check("min_diff", 32'(df[0]), 32'h4001);
`endif
    check("min_neg", 32'(ng[0]), 32'd1);
    tick();

    // Back-to-back with in_valid held high
    accept(14'd20, 14'd10, 1'b1);
    wait_out(lat, irl);
    check("b2b1_diff", 32'(df[0]), 32'd10);
    check("b2b1_in_ready_low", 32'(irl), 32'd1);
    a = 14'd16383;
    b = 14'd0;
    tick();
    check("b2b_idle_not_ready", 32'(ir[0]), 32'd0);
    accept(14'd16383, 14'd0, 1'b0);
    wait_out(lat, irl);
    check("b2b2_diff", 32'(df[0]), 32'd16383);
    check("b2b2_neg", 32'(ng[0]), 32'd0);
    check("b2b2_latency", 32'(lat), 32'd14);
    tick();

    // Backpressure plus operand changes during RUN
    out_ready = 1'b0;
    accept(14'd100, 14'd7, 1'b0);
    tick();
    a = 14'd3;
    b = 14'd9999;
    wait_out(lat, irl);
    check("bp_diff", 32'(df[0]), 32'd93);
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (!ov[0] || ir[0] || df[0] !== 15'd93 || ng[0] !== 1'b0) flag = 1'b0;
    end
    check("bp_hold_stable", 32'(flag), 32'd1);
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(ov[0]), 32'd0);
    check("bp_no_bypass", 32'(ir[0]), 32'd0);
    tick();
    check("bp_ready_back", 32'(ir[0]), 32'd1);

    // Abort with reset mid-RUN
    accept(14'd9, 14'd4, 1'b0);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 32'(ir[0]), 32'd1);
    check("abort_out_valid", 32'(ov[0]), 32'd0);
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (ov[0]) flag = 1'b0;
      tick();
    end
    check("abort_no_result", 32'(flag), 32'd1);
    accept(14'd5, 14'd3, 1'b0);
    wait_out(lat, irl);
    check("post_abort_diff", 32'(df[0]), 32'd2);
    tick();

    // Sweep every DIGIT instance against reference arithmetic
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if (n == 0) begin
        ra = 14'd0;
        rb = 14'h3FFF;
      end else if (n == 1) begin
        ra = 14'h1234;
        rb = 14'h1234;
      end else begin
        ra = 14'($urandom_range(0, 16383));
        rb = 14'($urandom_range(0, 16383));
      end
      check("sweep_all_ready", 32'(ir), 32'hF);
      a = ra;
      b = rb;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        seen[k] = 1'b0;
        lat_k[k] = 0;
        got[k] = '0;
        got_neg[k] = 1'b0;
      end
      for (int t = 1; t <= 17; t++) begin
        tick();
        for (int k = 0; k < 4; k++) begin
          if (ov[k] && !seen[k]) begin
            seen[k] = 1'b1;
            lat_k[k] = t;
            got[k] = df[k];
            got_neg[k] = ng[k];
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        check("sweep_seen", 32'(seen[k]), 32'd1);
        check("sweep_latency", 32'(lat_k[k]), 32'(14 / dig_of(k)));
        check("sweep_diff", 32'(got[k]), 32'(ref_diff(ra, rb)));
        check("sweep_neg", 32'(got_neg[k]), 32'(ra < rb));
      end
      $display("sweep %0d a=%0d b=%0d diff d1=%0h d2=%0h d7=%0h d14=%0h",
               n, ra, rb, got[0], got[1], got[2], got[3]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
